// File: rtl/csa_accumulator_pkg.sv
// Shared types, default widths and helpers for the carry-save accumulator.
// The operand and accumulator widths are set by the parameters of the instantiating module.
package csa_acc_pkg;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = N_DEF + 4;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Keeps only the low n bits of op, so the caller can widen an operand of any width.
  function automatic logic [63:0] zext_op(input logic [63:0] op, input int unsigned n);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    return op & mask;
  endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand stream in and result stream out for csa_accumulator.
// The producer and consumer side uses master; the accumulator uses slave.
import csa_acc_pkg::*;

interface csa_accumulator_if #(
  parameter int N  = N_DEF,
  parameter int W  = N + 4,
  parameter int CW = CW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/csa_accumulator_stage.sv
// One N-bit 3:2 compressor row: three operands in, a sum word and a carry word out.
// cout bit i carries weight 2^(i+1); the caller shifts it into place.
module carry_save_adder_stage #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] cin,
  output logic [N-1:0] sum,
  output logic [N-1:0] cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator that keeps its running total in carry-save form.
// It resolves the total with a single carry-propagate add after the last beat.
import csa_acc_pkg::*;

module csa_accumulator #(
  parameter int N  = N_DEF,
  parameter int W  = N + 4,
  parameter int CW = CW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_accumulator_if.slave  bus
);

  state_t        state;
  logic [W-1:0]  s_q;
  logic [W-1:0]  c_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  out_sum_q;
  logic [CW-1:0] out_count_q;
  logic          out_valid_q;

  logic [W-1:0]  operand;
  logic [W-1:0]  stage_sum;
  logic [W-1:0]  stage_cout;
  logic          accept;

  assign operand = W'(zext_op(64'(bus.in_data), N));
  assign accept  = bus.in_valid && (state == ACCUM);

  carry_save_adder_stage #(.N(W)) u_stage (
    .a    (s_q),
    .b    (c_q),
    .cin  (operand),
    .sum  (stage_sum),
    .cout (stage_cout)
  );

  // in_ready is decoded from the state alone, so it never depends on in_valid.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;

  // NOTE: every register, including the redundant S/C pair, is cleared in the reset branch,
  // so an interrupted partial sum can never leak into the next result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so each branch sees pre-edge values of all state.
      unique case (state)
        ACCUM: begin
          if (accept) begin
            s_q     <= stage_sum;
            // The carry word moves up one place; the carry out of the top bit wraps away.
            c_q     <= W'({stage_cout, 1'b0});
            count_q <= (count_q == '1) ? count_q : count_q + CW'(1);
            if (bus.in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum_q   <= s_q + c_q;
          out_count_q <= count_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and randomized checks of csa_accumulator with N=4, W=8.
// The expected totals come from a plain integer running sum taken modulo 256.
module tb_csa_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_accumulator_if #(.N(4), .W(8), .CW(8)) bus ();

  csa_accumulator #(.N(4), .W(8), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int unsigned run_sum = 0;
  int beats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sum();
    return 32'(run_sum % 256);
  endfunction

  function automatic logic [31:0] exp_count();
    return 32'((beats > 255) ? 255 : beats);
  endfunction

  task automatic clear_model();
    run_sum = 0;
    beats = 0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  // Present one beat, wait (bounded) for it to be accepted, then compare S+C with the model.
  task automatic send_beat(input logic [3:0] d, input logic last);
    int waited;
    logic [7:0] sc;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = last;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("in_ready_timeout", 32'(waited < 20), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    run_sum += d;
    beats++;
    sc = dut.s_q + dut.c_q;
    check("s_plus_c", 32'(sc), exp_sum());
  endtask

  // Called right after the last beat is accepted; the result must appear one edge later.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    check({tag, "_valid_not_early"}, 32'(bus.out_valid), 32'd0);
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd1);
    check({tag, "_sum"}, 32'(bus.out_sum), exp_sum());
    check({tag, "_count"}, 32'(bus.out_count), exp_count());
  endtask

  task automatic collect(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    clear_model();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    do_reset(2);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Sum of four
    for (int i = 0; i < 4; i++) send_beat(4'hF, i == 3);
    wait_result("four");
    check("four_sum_abs", 32'(bus.out_sum), 32'h3C);
    collect("four");

    // Wrap-around: 20 x 15 = 300 -> 44
    for (int i = 0; i < 20; i++) send_beat(4'hF, i == 19);
    wait_result("wrap");
    check("wrap_sum_abs", 32'(bus.out_sum), 32'h2C);
    check("wrap_count_abs", 32'(bus.out_count), 32'd20);
    collect("wrap");

    // Single beat with backpressure; a beat of 9 waits on the input meanwhile
    send_beat(4'd7, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data = 4'd9;
    bus.in_last = 1'b1;
    wait_result("single");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_sum", 32'(bus.out_sum), 32'd7);
      check("bp_out_count", 32'(bus.out_count), 32'd1);
    end
    collect("single");
    send_beat(4'd9, 1'b1);
    wait_result("after_bp");
    check("after_bp_sum_abs", 32'(bus.out_sum), 32'd9);
    collect("after_bp");

    // Mixed carries
    send_beat(4'hF, 1'b0);
    send_beat(4'h1, 1'b0);
    send_beat(4'hA, 1'b0);
    send_beat(4'h6, 1'b0);
    send_beat(4'h0, 1'b1);
    wait_result("mixed");
    check("mixed_sum_abs", 32'(bus.out_sum), 32'h20);
    collect("mixed");

    // Reset mid-sum
    send_beat(4'd3, 1'b0);
    send_beat(4'd5, 1'b0);
    do_reset(1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_sum", 32'(bus.out_sum), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_s_plus_c", 32'(8'(dut.s_q + dut.c_q)), 32'd0);
    send_beat(4'd2, 1'b0);
    send_beat(4'd4, 1'b1);
    wait_result("midrst");
    check("midrst_sum_abs", 32'(bus.out_sum), 32'd6);
    check("midrst_count_abs", 32'(bus.out_count), 32'd2);
    collect("midrst");

    // Reset while the result is waiting
    send_beat(4'd5, 1'b1);
    wait_result("donerst");
    do_reset(1);
    check("donerst_out_valid", 32'(bus.out_valid), 32'd0);
    check("donerst_in_ready", 32'(bus.in_ready), 32'd1);
    check("donerst_out_sum", 32'(bus.out_sum), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("donerst_stays_idle", 32'(bus.out_valid), 32'd0);
    end

    // Randomized sums with random consumer delay
    for (int t = 0; t < 6; t++) begin
      int len;
      int hold;
      len = int'($urandom_range(1, 30));
      for (int i = 0; i < len; i++) send_beat(4'($urandom_range(0, 15)), i == len - 1);
      wait_result("rand");
      hold = int'($urandom_range(0, 4));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check("rand_hold_sum", 32'(bus.out_sum), exp_sum());
      end
      collect("rand");
    end

    // Long sum: beat counter saturates at 255
    for (int i = 0; i < 300; i++) send_beat(4'($urandom_range(0, 15)), i == 299);
    wait_result("sat");
    check("sat_count_abs", 32'(bus.out_count), 32'd255);
    collect("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
